// File: rtl/cfu_simd_mac.sv
// CFU-bus responder: 4-lane signed int8 multiply-accumulate with a programmable input offset.
// One command is outstanding at a time. A MAC processes LANES_PER_CYCLE lanes in each BUSY cycle.
module cfu_simd_mac #(
  parameter int                LANES_PER_CYCLE = 1,
  parameter logic signed [8:0] RESET_OFFSET    = 9'sd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int STEPS = 4 / LANES_PER_CYCLE;

  localparam logic [2:0] OP_CLEAR  = 3'd0;
  localparam logic [2:0] OP_MAC    = 3'd1;
  localparam logic [2:0] OP_SETOFS = 3'd2;
  localparam logic [2:0] OP_READ   = 3'd3;
  localparam logic [2:0] OP_RDCLR  = 3'd4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state, state_next;
  logic [2:0]         funct3;
  logic [31:0]        acc;
  logic signed [8:0]  offset;
  logic [31:0]        a_q, b_q;
  logic [1:0]         step;
  logic               last_step;
  logic [31:0]        result;
  logic [31:0]        step_sum;
  logic signed [9:0]  a_ofs;
  logic signed [17:0] prod;

  // funct7 carries no meaning for this unit.
  logic unused_funct7;
  assign unused_funct7 = ^cmd_payload_function_id[9:3];

  assign funct3                = cmd_payload_function_id[2:0];
  assign last_step             = (step == 2'(STEPS - 1));
  assign cmd_ready             = (state == IDLE) && reset;
  assign rsp_valid             = (state == RESP);
  assign rsp_payload_outputs_0 = result;

  // Lowest LANES_PER_CYCLE lanes of the shifting operand registers, summed this cycle.
  always_comb begin
    // NOTE: blocking assignments here let each loop iteration build on the previous partial sum.
    step_sum = '0;
    a_ofs    = '0;
    prod     = '0;
    for (int j = 0; j < LANES_PER_CYCLE; j++) begin
      a_ofs    = 10'($signed(a_q[8*j +: 8])) + 10'(offset);
      prod     = 18'(a_ofs) * 18'($signed(b_q[8*j +: 8]));
      step_sum = step_sum + 32'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: assigning a default before the case keeps this process free of inferred latches.
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = (funct3 == OP_MAC) ? BUSY : RESP;
      BUSY:    if (last_step) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: every datapath register is reset, so an abandoned command leaves nothing behind.
      acc    <= '0;
      offset <= RESET_OFFSET;
      a_q    <= '0;
      b_q    <= '0;
      step   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          a_q  <= cmd_payload_inputs_0;
          b_q  <= cmd_payload_inputs_1;
          step <= '0;
          case (funct3)
            OP_CLEAR:  begin acc <= '0; result <= '0; end
            OP_MAC:    result <= result;
            OP_SETOFS: begin offset <= cmd_payload_inputs_0[8:0]; result <= '0; end
            OP_READ:   result <= acc;
            OP_RDCLR:  begin result <= acc; acc <= '0; end
            default:   result <= '0;
          endcase
        end
        BUSY: begin
          acc  <= acc + step_sum;
          a_q  <= a_q >> (8 * LANES_PER_CYCLE);
          b_q  <= b_q >> (8 * LANES_PER_CYCLE);
          step <= step + 2'd1;
          if (last_step) result <= acc + step_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfu_simd_mac.sv
// Directed bench for cfu_simd_mac: a table of single-command vectors plus hand-written
// sequences for back-pressure and mid-operation reset.
module tb_cfu_simd_mac;

  localparam int LANES = 1;
  localparam int STEPS = 4 / LANES;
  localparam int TMO   = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [9:0]  fid = '0;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0]  fid;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[19];

  cfu_simd_mac #(.LANES_PER_CYCLE(LANES), .RESET_OFFSET(9'sd0)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_payload_function_id(fid),
    .cmd_payload_inputs_0   (in0),
    .cmd_payload_inputs_1   (in1),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_payload_outputs_0  (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for cmd_ready, take the accepting edge, then scramble the bus.
  task automatic send_cmd(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                          input string name);
    int k = 0;
    cmd_valid = 1'b1;
    fid = f;
    in0 = a;
    in1 = b;
    while (!cmd_ready && k < TMO) begin
      tick();
      k++;
    end
    check({name, " accept"}, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    fid = 10'($urandom);
    in0 = $urandom;
    in1 = $urandom;
  endtask

  // Called in cycle N+1; counts cycles until rsp_valid, checking cmd_ready stays low throughout.
  task automatic wait_rsp(input string name, input int exp_lat, input logic [31:0] exp_data);
    int k = 0;
    bit ready_low = 1'b1;
    while (!rsp_valid && k < TMO) begin
      if (cmd_ready) ready_low = 1'b0;
      tick();
      k++;
    end
    check({name, " latency"}, 32'(k), 32'(exp_lat));
    check({name, " cmd_ready low"}, 32'(ready_low & !cmd_ready), 32'd1);
    check({name, " data"}, out, exp_data);
  endtask

  task automatic ack_rsp(input string name);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({name, " rsp drop"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic run_cmd(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
    send_cmd(f, a, b, name);
    wait_rsp(name, (f[2:0] == 3'd1) ? STEPS : 0, exp);
    ack_rsp(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    bit          stable;
    bit          quiet;

    // Offset starts at 0, acc at 0; expected values follow the sequence in order.
    vecs[0]  = '{10'h003, 32'h00000000, 32'h00000000, 32'h00000000}; // READ after reset
    vecs[1]  = '{10'h001, 32'h01020304, 32'h01010101, 32'h0000000A}; // 4+3+2+1
    vecs[2]  = '{10'h002, 32'h00000080, 32'h00000000, 32'h00000000}; // offset = 128
    vecs[3]  = '{10'h001, 32'hFFFFFFFF, 32'h02020202, 32'h00000402}; // 10 + 4*127*2
    vecs[4]  = '{10'h004, 32'h00000000, 32'h00000000, 32'h00000402}; // RDCLR
    vecs[5]  = '{10'h003, 32'h00000000, 32'h00000000, 32'h00000000}; // cleared
    vecs[6]  = '{10'h3FF, 32'h12345678, 32'h9ABCDEF0, 32'h00000000}; // funct3=7
    vecs[7]  = '{10'h001, 32'h80807F00, 32'h7F80FF01, 32'hFFFFFF81}; // 128-255+0+0 = -127
    vecs[8]  = '{10'h003, 32'h00000000, 32'h00000000, 32'hFFFFFF81};
    vecs[9]  = '{10'h00A, 32'hABCDE1FF, 32'h00000000, 32'h00000000}; // offset = -1, funct7 set
    vecs[10] = '{10'h001, 32'h80808080, 32'h80808080, 32'h00010181}; // -127 + 4*(-129*-128)
    vecs[11] = '{10'h002, 32'h00000100, 32'h00000000, 32'h00000000}; // offset = -256
    vecs[12] = '{10'h001, 32'h80808080, 32'h80808080, 32'h00040181}; // + 4*(-384*-128)
    vecs[13] = '{10'h3F8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000}; // CLEAR, funct7 set
    vecs[14] = '{10'h001, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'hFFFF0004}; // 4*(-129*127)
    vecs[15] = '{10'h001, 32'h80808080, 32'h80808080, 32'h00020004}; // wraps past 2^32
    vecs[16] = '{10'h002, 32'h00000000, 32'h00000000, 32'h00000000}; // offset = 0
    vecs[17] = '{10'h005, 32'h11111111, 32'h22222222, 32'h00000000}; // funct3=5
    vecs[18] = '{10'h003, 32'h00000000, 32'h00000000, 32'h00020004}; // acc untouched by 5/7

    reset = 1'b0;
    repeat (3) tick();
    check("reset cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset outputs", out, 32'h0);
    reset = 1'b1;
    #1;
    check("post-reset cmd_ready", 32'(cmd_ready), 32'd1);

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("stray rsp_ready", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < 19; i++)
      run_cmd(vecs[i].fid, vecs[i].in0, vecs[i].in1, vecs[i].exp, $sformatf("vec%0d", i));

    // Back-pressure: response held 10 cycles while a second command waits.
    send_cmd(10'h001, 32'h01010101, 32'h01010101, "hold mac");
    cmd_valid = 1'b1;
    fid = 10'h003;
    in0 = '0;
    in1 = '0;
    wait_rsp("hold mac", STEPS, 32'h00020008);
    held = out;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (!rsp_valid || out !== held || cmd_ready) stable = 1'b0;
    end
    check("hold stable", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("hold rsp drop", 32'(rsp_valid), 32'd0);
    check("hold idle ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    wait_rsp("hold read", 0, 32'h00020008);
    ack_rsp("hold read");

    // Reset during the second BUSY cycle of a MAC with a non-default offset.
    run_cmd(10'h002, 32'h00000005, 32'h0, 32'h0, "pre-abort setofs");
    send_cmd(10'h001, 32'h01020304, 32'h01010101, "abort mac");
    tick();
    reset = 1'b0;
    tick();
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort cmd_ready", 32'(cmd_ready), 32'd0);
    check("abort outputs", out, 32'h0);
    tick();
    reset = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      tick();
      if (rsp_valid) quiet = 1'b0;
    end
    check("abort no response", 32'(quiet), 32'd1);
    check("abort ready again", 32'(cmd_ready), 32'd1);
    run_cmd(10'h003, 32'h0, 32'h0, 32'h00000000, "abort read");
    run_cmd(10'h001, 32'h01020304, 32'h01010101, 32'h0000000A, "abort offset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
